// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and legal WIDTH range for the Gray pointer counter
// and its converters. Helpers work on the widest legal code. Callers zero-extend
// the input and truncate the result. Zero upper bits do not disturb the low bits
// of either transform.
package gray_pkg;

    localparam int unsigned GRAY_WIDTH_MIN = 2;
    localparam int unsigned GRAY_WIDTH_MAX = 16;

    // Binary to Gray: g = b ^ (b >> 1)
    function automatic logic [GRAY_WIDTH_MAX-1:0] bin2gray(input logic [GRAY_WIDTH_MAX-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Gray to binary: prefix XOR from the MSB down
    function automatic logic [GRAY_WIDTH_MAX-1:0] gray2bin(input logic [GRAY_WIDTH_MAX-1:0] gray);
        logic [GRAY_WIDTH_MAX-1:0] bin;
        bin[GRAY_WIDTH_MAX-1] = gray[GRAY_WIDTH_MAX-1];
        for (int i = int'(GRAY_WIDTH_MAX) - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/converter_bin_gray.sv
// Combinational binary-to-Gray converter.
module converter_bin_gray
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin_i,
    output logic [WIDTH-1:0] gray_o
);

    // Encode through the shared package helper
    assign gray_o = WIDTH'(bin2gray(GRAY_WIDTH_MAX'(bin_i)));

endmodule

// File: rtl/converter_gray_bin.sv
// Combinational Gray-to-binary converter.
module converter_gray_bin
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    // Decode through the shared package helper
    assign bin_o = WIDTH'(gray2bin(GRAY_WIDTH_MAX'(gray_i)));

endmodule

// File: rtl/gray_ptr_counter.sv
// Gray-coded pointer counter. The binary count and its Gray code are
// registered in the same flop stage. gray_next shows the code the counter
// takes at the next edge.
// Optional feature: define GRAY_PTR_LOAD_EN to add the load/load_bin port and
// load path.
// Update priority is rst > clr > load > inc_en.
module gray_ptr_counter
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_en,
    input  logic             clr,
`ifdef GRAY_PTR_LOAD_EN
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
`endif
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] gray_next,
    output logic             wrap
);

    // Reject illegal widths at elaboration
    if (WIDTH < GRAY_WIDTH_MIN || WIDTH > GRAY_WIDTH_MAX) begin : g_bad_width
        $error("gray_ptr_counter: WIDTH out of range");
    end

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q;
    logic             wrap_q, wrap_d;

    // Next binary value by priority. Only an increment out of all-ones flags a wrap.
    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (rst) begin
            bin_d = '0;
        end else if (clr) begin
            bin_d = '0;
`ifdef GRAY_PTR_LOAD_EN
        end else if (load) begin
            bin_d = load_bin;
`endif
        end else if (inc_en) begin
            bin_d  = bin_q + WIDTH'(1);
            wrap_d = (bin_q == {WIDTH{1'b1}});
        end
    end

    // Gray code of the next value. It also feeds the gray_out flop.
    converter_bin_gray #(
        .WIDTH (WIDTH)
    ) u_bin_gray (
        .bin_i  (bin_d),
        .gray_o (gray_next)
    );

    // Binary, Gray and wrap state, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_next;
            wrap_q <= wrap_d;
        end
    end

    assign bin_out  = bin_q;
    assign gray_out = gray_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_gray_ptr_counter.sv
// Self-checking bench for gray_ptr_counter (WIDTH=4). A counting model holds an
// integer count. Each step also checks that the predicted gray_next shows up on
// gray_out one edge later.
// The load scenario is included only when GRAY_PTR_LOAD_EN is defined.
module tb_gray_ptr_counter;

    localparam int unsigned W   = 4;
    localparam int unsigned MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic         inc_en;
    logic         clr;
`ifdef GRAY_PTR_LOAD_EN
    logic         load;
    logic [W-1:0] load_bin;
`endif
    logic [W-1:0] bin_out;
    logic [W-1:0] gray_out;
    logic [W-1:0] gray_next;
    logic         wrap;
    logic [W-1:0] dec_bin;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference model state
    int unsigned m_bin  = 0;
    bit          m_wrap = 1'b0;

    always #5 clk = ~clk;

    gray_ptr_counter #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .inc_en    (inc_en),
        .clr       (clr),
`ifdef GRAY_PTR_LOAD_EN
        .load      (load),
        .load_bin  (load_bin),
`endif
        .bin_out   (bin_out),
        .gray_out  (gray_out),
        .gray_next (gray_next),
        .wrap      (wrap)
    );

    converter_gray_bin #(
        .WIDTH (W)
    ) u_dec (
        .gray_i (gray_out),
        .bin_o  (dec_bin)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned gray_of(input int unsigned n);
        return n ^ (n >> 1);
    endfunction

    // One clock cycle. It drives the inputs, checks gray_next, advances the
    // model and then checks all registered outputs.
    task automatic cycle(input bit r, input bit c, input bit ld, input int unsigned lb, input bit inc);
        int unsigned nb;
        bit          nw;
        bit          incd;
        logic [W-1:0] gn_seen;
        logic [W-1:0] prev_gray;
        rst    = r;
        clr    = c;
        inc_en = inc;
`ifdef GRAY_PTR_LOAD_EN
        load     = ld;
        load_bin = W'(lb);
`endif
        nb   = m_bin;
        nw   = 1'b0;
        incd = 1'b0;
        if (r)        nb = 0;
        else if (c)   nb = 0;
        else if (ld)  nb = lb % MOD;
        else if (inc) begin
            nb   = (m_bin + 1) % MOD;
            nw   = (m_bin == MOD - 1);
            incd = 1'b1;
        end
        #1;
        check("gray_next", 32'(gray_next), gray_of(nb));
        gn_seen   = gray_next;
        prev_gray = gray_out;
        @(posedge clk);
        #1;
        m_bin  = nb;
        m_wrap = nw;
        check("bin_out", 32'(bin_out), m_bin);
        check("gray_out", 32'(gray_out), gray_of(m_bin));
        check("wrap", 32'(wrap), 32'(m_wrap));
        check("next_to_out", 32'(gray_out), 32'(gn_seen));
        check("decode", 32'(dec_bin), m_bin);
        if (incd) check("hamming", $countones(prev_gray ^ gray_out), 1);
    endtask

    initial begin : main
        int unsigned seq [16];
        seq = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};
        rst    = 1'b1;
        clr    = 1'b0;
        inc_en = 1'b0;
`ifdef GRAY_PTR_LOAD_EN
        load     = 1'b0;
        load_bin = '0;
`endif
        @(posedge clk);
        #1;

        // Reset state, with inc_en held high to show it is ignored
        cycle(1, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0);
        check("rst_bin", 32'(bin_out), 0);
        check("rst_gray", 32'(gray_out), 0);
        check("rst_wrap", 32'(wrap), 0);

        // Full Gray sequence with the wrap pulse
        for (int i = 0; i < 16; i++) begin
            cycle(0, 0, 0, 0, 1);
            check("seq_gray", 32'(gray_out), seq[(i + 1) % 16]);
            check("seq_wrap", 32'(wrap), (i == 15) ? 1 : 0);
        end
        cycle(0, 0, 0, 0, 1);
        check("wrap_drop", 32'(wrap), 0);
        cycle(0, 0, 0, 0, 0);
        check("hold_bin", 32'(bin_out), 1);

        // Clear beats increment at all-ones, with no wrap
        for (int i = 0; i < 16 && m_bin != MOD - 1; i++) cycle(0, 0, 0, 0, 1);
        check("pre_clr_bin", 32'(bin_out), MOD - 1);
        cycle(0, 1, 0, 0, 1);
        check("clr_bin", 32'(bin_out), 0);
        check("clr_gray", 32'(gray_out), 0);
        check("clr_wrap", 32'(wrap), 0);

`ifdef GRAY_PTR_LOAD_EN
        // Load beats increment. Then count on from the loaded value.
        cycle(0, 0, 1, 4'b1010, 1);
        check("load_bin", 32'(bin_out), 4'b1010);
        check("load_gray", 32'(gray_out), 4'b1111);
        cycle(0, 0, 0, 0, 1);
        check("load_inc_bin", 32'(bin_out), 4'b1011);
        check("load_inc_gray", 32'(gray_out), 4'b1110);
        // A load from all-ones gives no wrap
        for (int i = 0; i < 16 && m_bin != MOD - 1; i++) cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 1, 3, 1);
        check("load_wrap", 32'(wrap), 0);
        cycle(0, 1, 0, 0, 0);
`endif

        // Reset mid-count at 7 while incrementing, then resume from zero
        for (int i = 0; i < 16 && m_bin != 7; i++) cycle(0, 0, 0, 0, 1);
        check("pre_rst_bin", 32'(bin_out), 7);
        rst    = 1'b1;
        inc_en = 1'b1;
        #1;
        check("rst_gray_next", 32'(gray_next), 0);
        cycle(1, 0, 0, 0, 1);
        check("mid_rst_bin", 32'(bin_out), 0);
        check("mid_rst_gray", 32'(gray_out), 0);
        cycle(0, 0, 0, 0, 1);
        check("resume_bin", 32'(bin_out), 1);

        // Random increments with rare clear, reset and load
        for (int i = 0; i < 200; i++) begin
            bit r, c, ld;
            r  = ($urandom_range(0, 63) == 0);
            c  = ($urandom_range(0, 31) == 0);
`ifdef GRAY_PTR_LOAD_EN
            ld = ($urandom_range(0, 31) == 0);
`else
            ld = 1'b0;
`endif
            cycle(r, c, ld, $urandom_range(0, MOD - 1), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
